// File: rtl/regfile_mp.sv
// Multi-read-port register file with a reset-time clearing sweep and a pending-write scoreboard.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int LINK_REG = 31,
  parameter int XP_REG   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    RegWrite,
  input  logic [1:0]              RegDst,
  input  logic [ADDR_W-1:0]       rt,
  input  logic [ADDR_W-1:0]       rd,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_pend,
  input  logic                    pend_set,
  input  logic [ADDR_W-1:0]       pend_addr,
  output logic                    ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {SWEEP, RUN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   idx, idx_nxt;
  logic [ADDR_W-1:0]   wa;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    pend;
  logic                we_eff;
  logic                ps_eff;

  always_comb begin
    case (RegDst)
      2'b01:   wa = rt;
      2'b10:   wa = ADDR_W'(LINK_REG);
      2'b11:   wa = ADDR_W'(XP_REG);
      default: wa = rd;
    endcase
  end

  assign ready  = (state == RUN);
  assign we_eff = ready && RegWrite && (wa != '0);
  assign ps_eff = ready && pend_set && (pend_addr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SWEEP;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Sweep walks every register once, then the file becomes usable.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      SWEEP: begin
        idx_nxt = idx + ADDR_W'(1);
        if (idx == '1) state_nxt = RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == SWEEP)
      mem[idx] <= '0;
    else if (we_eff)
      mem[wa] <= wdata;
  end

  // Set after clear so a same-cycle re-issue keeps the bit pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      if (we_eff) pend[wa] <= 1'b0;
      if (ps_eff) pend[pend_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    for (int i = 0; i < NREAD; i++) begin
      logic [ADDR_W-1:0] ra;
      ra = rd_addr[i*ADDR_W +: ADDR_W];
      if (ready && (ra != '0)) begin
        rd_data[i*DATA_W +: DATA_W] = mem[ra];
        rd_pend[i]                  = pend[ra];
`ifdef REGFILE_BYPASS_EN
        if (we_eff && (ra == wa)) begin
          rd_data[i*DATA_W +: DATA_W] = wdata;
          if (!(ps_eff && (pend_addr == wa))) rd_pend[i] = 1'b0;
        end
`endif
      end
    end
  end

endmodule
